// File: rtl/des3_cbc_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// des3_seq_pkg
// Shared types and constants for the DES3 CBC sequencer.
//   seq_state_e : sequencer FSM states (IDLE, START, WAIT, OUT)
//   DES_BLK_W   : DES block width in bits
//   WDOG_W      : watchdog counter width (covers TIMEOUT up to 65535)
//   core_in_blk : block presented to the core for a given mode
// -----------------------------------------------------------------------------
package des3_seq_pkg;

  localparam int DES_BLK_W = 64;
  localparam int WDOG_W    = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    OUT   = 2'd3
  } seq_state_e;

  // Only CBC encryption pre-whitens the block with the chain; CBC decryption
  // applies the chain after the core, and ECB never uses it.
  function automatic logic [DES_BLK_W-1:0] core_in_blk(
    input logic [DES_BLK_W-1:0] blk,
    input logic [DES_BLK_W-1:0] chain,
    input logic                 dec,
    input logic                 cbc
  );
    return (!dec && cbc) ? (blk ^ chain) : blk;
  endfunction

endpackage

// File: rtl/des3_cbc_sequencer_if.sv
// -----------------------------------------------------------------------------
// des3_cbc_sequencer_if
// Bundles the sequencer's configuration, input/output streams and the core pins.
//   master : the sequencer side (drives in_ready, out_*, err, core_start/desIn/decrypt)
//   slave  : the environment side (drives config, in_*, out_ready and the core results)
// -----------------------------------------------------------------------------
interface des3_cbc_sequencer_if;
  import des3_seq_pkg::*;

  // configuration
  logic                 iv_load;
  logic [DES_BLK_W-1:0] iv;
  logic                 mode_dec;
  logic                 cbc_en;
  // input stream
  logic                 in_valid;
  logic                 in_ready;
  logic [DES_BLK_W-1:0] in_data;
  // output stream
  logic                 out_valid;
  logic                 out_ready;
  logic [DES_BLK_W-1:0] out_data;
  logic                 err;
  // DES3 core pins
  logic                 core_start;
  logic [DES_BLK_W-1:0] core_desIn;
  logic                 core_decrypt;
  logic [DES_BLK_W-1:0] core_desOut;
  logic                 core_out_valid;

  modport master (
    input  iv_load, iv, mode_dec, cbc_en,
    input  in_valid, in_data,
    output in_ready,
    output out_valid, out_data, err,
    input  out_ready,
    output core_start, core_desIn, core_decrypt,
    input  core_desOut, core_out_valid
  );

  modport slave (
    output iv_load, iv, mode_dec, cbc_en,
    output in_valid, in_data,
    input  in_ready,
    input  out_valid, out_data, err,
    output out_ready,
    input  core_start, core_desIn, core_decrypt,
    output core_desOut, core_out_valid
  );

endinterface

// File: rtl/des3_cbc_sequencer.sv
// -----------------------------------------------------------------------------
// des3_cbc_sequencer
// Feeds 64-bit blocks to a DES3 core one at a time, applying CBC chaining
// (or ECB pass-through), waits for a qualified core result, un-chains it and
// holds it in a one-entry output buffer. A watchdog aborts a block whose
// core never answers and raises a sticky err flag.
//
// Parameters:
//   TIMEOUT : WAIT cycles allowed before abort (1..65535)
// Ports:
//   clk   : sole clock, rising edge
//   reset : asynchronous, active-high
//   bus   : des3_cbc_sequencer_if.master (config, in/out streams, core pins)
// -----------------------------------------------------------------------------
module des3_cbc_sequencer
  import des3_seq_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input logic                   clk,
  input logic                   reset,
  des3_cbc_sequencer_if.master  bus
);

  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

  seq_state_e           state_q;
  logic [DES_BLK_W-1:0] blk_q;
  logic [DES_BLK_W-1:0] chain_q;
  logic                 dec_q;
  logic                 cbc_q;
  logic [DES_BLK_W-1:0] desin_q;
  logic                 decrypt_q;
  logic                 start_q;
  logic                 seen_low_q;
  logic [WDOG_W-1:0]    wdog_q;
  logic [DES_BLK_W-1:0] out_data_q;
  logic                 out_valid_q;
  logic                 err_q;

  logic                 in_ready_d;
  logic [DES_BLK_W-1:0] desin_d;
  logic                 capture_d;

  // iv_load takes priority over a block offer; reset holds ready low so no
  // block can be considered accepted while the sequencer is being cleared.
  assign in_ready_d = (state_q == IDLE) && !bus.iv_load && !reset;
  assign desin_d    = core_in_blk(bus.in_data, chain_q, dec_q, cbc_q);
  // A result counts only once valid has been seen low in WAIT, so a valid
  // left high from reset or from the previous block is never captured.
  assign capture_d  = bus.core_out_valid && seen_low_q;

  // NOTE: every register here uses non-blocking assignments so all state
  // updates see the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      blk_q       <= '0;
      chain_q     <= '0;
      dec_q       <= 1'b0;
      cbc_q       <= 1'b0;
      desin_q     <= '0;
      decrypt_q   <= 1'b0;
      start_q     <= 1'b0;
      seen_low_q  <= 1'b0;
      wdog_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.iv_load) begin
            chain_q <= bus.iv;
            dec_q   <= bus.mode_dec;
            cbc_q   <= bus.cbc_en;
            err_q   <= 1'b0;
          end else if (bus.in_valid) begin
            blk_q     <= bus.in_data;
            desin_q   <= desin_d;
            decrypt_q <= dec_q;
            start_q   <= 1'b1;
            state_q   <= START;
          end
        end

        // core_out_valid is deliberately not looked at here.
        START: begin
          seen_low_q <= 1'b0;
          wdog_q     <= '0;
          state_q    <= WAIT;
        end

        WAIT: begin
          if (capture_d) begin
            out_valid_q <= 1'b1;
            state_q     <= OUT;
            if (!dec_q) begin
              out_data_q <= bus.core_desOut;
              if (cbc_q) chain_q <= bus.core_desOut;
            end else if (cbc_q) begin
              out_data_q <= bus.core_desOut ^ chain_q;
              chain_q    <= blk_q;
            end else begin
              out_data_q <= bus.core_desOut;
            end
          end else if (wdog_q == WDOG_LAST) begin
            // Abort: block dropped, chain left untouched.
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            wdog_q <= wdog_q + 1'b1;
            if (!bus.core_out_valid) seen_low_q <= 1'b1;
          end
        end

        OUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready     = in_ready_d;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
  assign bus.err          = err_q;
  assign bus.core_start   = start_q;
  assign bus.core_desIn   = desin_q;
  assign bus.core_decrypt = decrypt_q;

endmodule

// File: tb/tb_des3_cbc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_des3_cbc_sequencer
// Self-checking bench for des3_cbc_sequencer. A behavioural core stub answers
// with desIn ^ A5.. after a configurable latency (optionally holding a stale
// valid first, or never answering). Expected results come from a CBC/ECB
// reference model kept as plain chain/mode variables.
// -----------------------------------------------------------------------------
module tb_des3_cbc_sequencer;

  localparam int          TO   = 8;
  localparam logic [63:0] KEY  = 64'hA5A5_A5A5_A5A5_A5A5;
  localparam logic [63:0] JUNK = 64'hDEAD_BEEF_0BAD_F00D;

  logic clk = 1'b0;
  logic reset;

  des3_cbc_sequencer_if bus ();

  des3_cbc_sequencer #(.TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Core stub, driven on the falling edge. k counts cycles since the START
  // cycle; k in 1..stub_stale keeps a stale valid with junk data, k >= stub_L
  // presents the real answer, anything else is low.
  // ---------------------------------------------------------------------------
  int          stub_L     = 5;
  int          stub_stale = 0;
  bit          stub_dead  = 1'b0;
  int          cyc        = 0;
  int          st_cyc     = 0;
  bit          started    = 1'b0;
  logic [63:0] stub_in    = '0;

  always @(negedge clk) begin
    if (reset) begin
      started            = 1'b0;
      bus.core_out_valid = 1'b1;
      bus.core_desOut    = JUNK;
    end else begin
      cyc++;
      if (bus.core_start) begin
        started = 1'b1;
        st_cyc  = cyc;
        stub_in = bus.core_desIn;
      end else if (started) begin
        if (cyc - st_cyc <= stub_stale) begin
          bus.core_out_valid = 1'b1;
          bus.core_desOut    = JUNK;
        end else if (!stub_dead && (cyc - st_cyc >= stub_L)) begin
          bus.core_out_valid = 1'b1;
          bus.core_desOut    = stub_in ^ KEY;
        end else begin
          bus.core_out_valid = 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model: chaining value and latched mode.
  // ---------------------------------------------------------------------------
  logic [63:0] m_chain = '0;
  logic        m_dec   = 1'b0;
  logic        m_cbc   = 1'b0;

  task automatic load_iv(input logic [63:0] v, input logic d, input logic c);
    @(negedge clk);
    bus.iv_load  = 1'b1;
    bus.iv       = v;
    bus.mode_dec = d;
    bus.cbc_en   = c;
    bus.in_valid = 1'b1;
    bus.in_data  = {$urandom, $urandom};
    #1;
    check("iv_load_blocks_ready", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    bus.iv_load  = 1'b0;
    bus.in_valid = 1'b0;
    check("iv_load_no_start", 64'(bus.core_start), 64'd0);
    check("iv_load_clears_err", 64'(bus.err), 64'd0);
    m_chain = v;
    m_dec   = d;
    m_cbc   = c;
  endtask

  // Sends one block, checks the core pins, latency and result, applies bp
  // cycles of backpressure, and optionally pulses iv_load during WAIT.
  task automatic run_block(input logic [63:0] p, input int bp, input bit poke_iv,
                           output logic [63:0] res);
    logic [63:0] exp_in, exp_out, hold;
    int          n;
    bit          got;
    if (!m_dec) begin
      exp_in  = m_cbc ? (p ^ m_chain) : p;
      exp_out = exp_in ^ KEY;
    end else begin
      exp_in  = p;
      exp_out = (p ^ KEY) ^ (m_cbc ? m_chain : 64'd0);
    end
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = p;
    #1;
    check("in_ready_idle", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("core_start", 64'(bus.core_start), 64'd1);
    check("core_desIn", bus.core_desIn, exp_in);
    check("core_decrypt", 64'(bus.core_decrypt), 64'(m_dec));
    n   = 0;
    got = 1'b0;
    while (n < 64 && !got) begin
      @(negedge clk);
      n++;
      bus.iv_load = poke_iv && (n == 1);
      if (bus.iv_load) begin
        bus.iv       = {$urandom, $urandom};
        bus.mode_dec = ~m_dec;
        bus.cbc_en   = ~m_cbc;
      end
      if (bus.out_valid) got = 1'b1;
    end
    bus.iv_load = 1'b0;
    check("out_latency", 64'(n), 64'(stub_L + 1));
    check("out_data", bus.out_data, exp_out);
    res  = bus.out_data;
    hold = bus.out_data;
    if (bp > 0) begin
      repeat (bp) @(negedge clk);
      check("bp_data_stable", bus.out_data, hold);
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
      check("bp_out_valid", 64'(bus.out_valid), 64'd1);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("ready_after_out", 64'(bus.in_ready), 64'd1);
    check("out_valid_drop", 64'(bus.out_valid), 64'd0);
    if (m_cbc) m_chain = m_dec ? p : exp_out;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd0);
    check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_out_data"}, bus.out_data, 64'd0);
    check({tag, "_err"}, 64'(bus.err), 64'd0);
    check({tag, "_core_start"}, 64'(bus.core_start), 64'd0);
    check({tag, "_core_desIn"}, bus.core_desIn, 64'd0);
    check({tag, "_core_decrypt"}, 64'(bus.core_decrypt), 64'd0);
  endtask

  initial begin
    logic [63:0] r, c1, c2, p, v;
    int          n;
    bit          got;

    reset         = 1'b1;
    bus.iv_load   = 1'b0;
    bus.iv        = '0;
    bus.mode_dec  = 1'b0;
    bus.cbc_en    = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    bus.core_out_valid = 1'b1;
    bus.core_desOut    = JUNK;

    // Reset state.
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    #1;
    check("in_ready_after_reset", 64'(bus.in_ready), 64'd1);

    // ECB encrypt, L=5; stub still holds its post-reset stale valid.
    load_iv(64'h1111_2222_3333_4444, 1'b0, 1'b0);
    stub_L = 5;
    run_block(64'h0123_4567_89AB_CDEF, 0, 1'b0, r);
    check("ecb_known_answer", r, 64'hA486_E0C2_2C0E_684A);

    // CBC encrypt of two blocks, then decrypt them back.
    v = 64'hFFFF_0000_FFFF_0000;
    load_iv(v, 1'b0, 1'b1);
    stub_L = 4;
    run_block(64'h0, 0, 1'b0, c1);
    check("cbc_enc_blk1", c1, v ^ KEY);
    run_block(64'h1, 1, 1'b0, c2);
    check("cbc_enc_blk2", c2, (c1 ^ 64'h1) ^ KEY);
    load_iv(v, 1'b1, 1'b1);
    stub_L = 3;
    run_block(c1, 0, 1'b0, r);
    check("cbc_dec_blk1", r, 64'h0);
    run_block(c2, 2, 1'b0, r);
    check("cbc_dec_blk2", r, 64'h1);

    // Stale valid held into WAIT must not be captured.
    stub_L = 6; stub_stale = 3;
    run_block(64'h5555_AAAA_0F0F_F0F0, 0, 1'b1, r);
    stub_stale = 0;

    // Capture on the TIMEOUT-th WAIT cycle beats the watchdog.
    load_iv(64'hC0FF_EE00_1234_5678, 1'b0, 1'b1);
    stub_L = TO;
    run_block(64'h0BAD_CAFE_DEAD_BEEF, 0, 1'b0, r);
    check("capture_wins_err", 64'(bus.err), 64'd0);

    // Watchdog: core never answers.
    stub_dead = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 64'h7777_8888_9999_AAAA;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("wdog_start", 64'(bus.core_start), 64'd1);
    n = 0; got = 1'b0;
    while (n < 64 && !got) begin
      @(negedge clk);
      n++;
      if (bus.err) got = 1'b1;
    end
    check("wdog_cycles", 64'(n), 64'(TO + 1));
    check("wdog_in_ready", 64'(bus.in_ready), 64'd1);
    check("wdog_no_out", 64'(bus.out_valid), 64'd0);
    stub_dead = 1'b0;
    stub_L    = 4;
    run_block(64'h1357_9BDF_2468_ACE0, 0, 1'b0, r);   // chain must be untouched
    check("err_sticky", 64'(bus.err), 64'd1);
    load_iv(64'h0, 1'b0, 1'b0);

    // Backpressure for 10 cycles.
    run_block(64'hFEDC_BA98_7654_3210, 10, 1'b0, r);

    // Reset in the middle of WAIT.
    load_iv(64'hAAAA_5555_AAAA_5555, 1'b1, 1'b1);
    stub_dead = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 64'h2222_4444_6666_8888;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1 check_reset_outputs("midwait");
    @(negedge clk);
    reset     = 1'b0;
    stub_dead = 1'b0;
    m_chain = '0; m_dec = 1'b0; m_cbc = 1'b0;
    @(negedge clk);
    check("ready_after_midreset", 64'(bus.in_ready), 64'd1);
    p = {$urandom, $urandom};
    stub_L = 5;
    run_block(p, 0, 1'b0, r);
    check("post_reset_ecb", r, p ^ KEY);

    // Randomized traffic against the model.
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) == 0)
        load_iv({$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      stub_L     = $urandom_range(2, TO);
      stub_stale = $urandom_range(0, stub_L - 2);
      run_block({$urandom, $urandom}, $urandom_range(0, 3), 1'($urandom_range(0, 1)), r);
    end
    stub_stale = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/des3_cbc_sequencer.md
# des3_cbc_sequencer

Upstream/downstream companion to the DES3 LLKI-wrapped core. It accepts 64-bit blocks over a valid/ready stream, applies CBC chaining (or ECB pass-through), and drives the core's `start`/`desIn`/`decrypt` pins. It waits for a qualified `out_valid`, un-chains the result, and presents it on a one-entry valid/ready output buffer. A watchdog guards against a core that never answers, for example one held locked by LLKI.

## Interface

Parameters:
- `TIMEOUT`, default 255: cycles allowed in WAIT before abort (1..65535).

Ports (one clock; reset is asynchronous and active-high):
- `clk` input 1: sole clock, all state on rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `iv_load` input 1: in IDLE, loads `iv`, `mode_dec`, `cbc_en`; clears `err`.
- `iv` input 64: initial chaining value.
- `mode_dec` input 1: 1 = decrypt, 0 = encrypt; latched on `iv_load`.
- `cbc_en` input 1: 1 = CBC, 0 = ECB (chain ignored); latched on `iv_load`.
- `in_valid` input 1: input block present.
- `in_ready` output 1: sequencer accepts a block this cycle.
- `in_data` input 64: plaintext (encrypt) or ciphertext (decrypt).
- `out_valid` output 1: result held in output buffer.
- `out_ready` input 1: downstream consumes result.
- `out_data` output 64: result block.
- `err` output 1: sticky watchdog-abort flag.
- `core_start` output 1: one-cycle start pulse to core.
- `core_desIn` output 64: core data input.
- `core_decrypt` output 1: core direction.
- `core_desOut` input 64: core data output.
- `core_out_valid` input 1: core result valid.

## Operation

- States: IDLE, START, WAIT, OUT.
- IDLE: `in_ready`=1 unless `iv_load`=1 that cycle (`iv_load` wins; block not accepted). On accept: latch `in_data` into `blk_reg` and go to START.
- Core input:
  - encrypt+CBC: `core_desIn` = `blk_reg ^ chain`.
  - otherwise: `core_desIn` = `blk_reg`.
- `core_desIn` and `core_decrypt` are registered and stable from START until capture.
- START: `core_start`=1 for exactly this cycle; clear `seen_low` and the watchdog counter; go to WAIT.
- WAIT:
  - Set `seen_low` when `core_out_valid`=0.
  - Capture when `core_out_valid`=1 && `seen_low`=1. This rejects stale or reset-asserted valid.
- Capture results:
  - encrypt: `out_data` = `core_desOut`; chain ← `core_desOut` (CBC).
  - decrypt+CBC: `out_data` = `core_desOut ^ chain`; chain ← `blk_reg`.
  - ECB: `out_data` = `core_desOut`; chain unchanged.
  - Then go to OUT.
- Watchdog: counter increments each WAIT cycle. When it reaches `TIMEOUT` with no capture: set `err`, discard the block, go to IDLE; chain unchanged, no output.
- OUT: `out_valid`=1, `out_data` stable. On `out_ready`: go to IDLE.
- `iv_load` outside IDLE is ignored.
- All arithmetic is bitwise XOR on 64 bits; no carries.

## Timing

- Reset values: `in_ready`=0 during reset and 1 the first cycle after; `out_valid`=0, `out_data`=0, `err`=0, `core_start`=0, `core_desIn`=0, `core_decrypt`=0; chain=0, `cbc_en`=0, `mode_dec`=0; state IDLE.
- Accept at edge N → `core_start`=1 in cycle N+1.
- Qualified `core_out_valid` sampled at edge M → `out_valid`=1 from cycle M+1.
- After the `out_ready` handshake, `in_ready`=1 the next cycle. No overlap: at most one block in flight.
- `core_out_valid` high during START is ignored, and does not set `seen_low`.
- Reset mid-operation (any state) aborts immediately. The in-flight block and chain are lost; the core sees `core_start`=0.
- Watchdog fires on the TIMEOUT-th WAIT cycle. If a qualified valid arrives on that same cycle, capture wins and `err` stays 0.

## Structure

- Package `des3_seq_pkg`: `seq_state_e` enum (IDLE, START, WAIT, OUT), `DES_BLK_W`=64, `WDOG_W`=16.
- Single module; no sub-module required.
- The bench uses a behavioural core stub: `desOut` = `desIn ^ 64'hA5A5_A5A5_A5A5_A5A5`, fixed latency L (configurable), `out_valid` high after reset until the first `start`.

## Test plan

- ECB encrypt: `iv_load` with `cbc_en`=0, `mode_dec`=0; send `64'h0123_4567_89AB_CDEF` with L=5 → `core_start` one cycle after accept; `out_data`=`64'hA486_E0C2_2C0E_684A`; `out_valid` 6 cycles after START.
- CBC encrypt of two blocks: `iv`=`64'hFFFF_0000_FFFF_0000`, blocks `64'h0`, `64'h1`.
  - Block 1: `core_desIn`=iv; out1 = iv ^ A5… .
  - Block 2: `core_desIn` = out1 ^ 1.
- CBC decrypt of the ciphertexts from the CBC encrypt test with the same iv → outputs `64'h0`, `64'h1`.
- Stale valid after reset: stub holds `out_valid`=1 until START; capture only after the low-then-high transition; `out_data` is the correct value.
- Watchdog: stub never responds, `TIMEOUT`=8 → `err`=1 exactly 8 WAIT cycles after START; `in_ready`=1 next cycle; chain unchanged; the next `iv_load` clears `err`.
- Backpressure and reset: hold `out_ready`=0 for 10 cycles → `out_data` stable and `in_ready`=0; assert `reset` mid-WAIT → all outputs at reset values within the same cycle.
